pulse_stretch: RTL and testbench
================================

PULSE_STRETCH -- requirements
Module: pulse_stretch

Interface
REQ-001 Parameter DIV_W, default 15, sets prescaler width; one tick every 2^DIV_W clk cycles.
REQ-002 Parameter ON_TICKS, default 10, sets output high time in ticks; legal range 1..255.
REQ-003 Parameter OFF_TICKS, default 2, sets minimum output low gap in ticks between pulses; legal range 0..255.
REQ-004 clk  input  1  single system clock; all logic on posedge clk.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 trig  input  1  synchronous event request; sampled every clk cycle, one-cycle pulses accepted.
REQ-007 outsig  output  1  stretched pulse toward LED or indicator; registered.
REQ-008 busy  output  1  high whenever state is not IDLE or a trigger is pending; registered.

Function
REQ-009 Prescaler: free-running DIV_W-bit up-counter, wraps to 0; tick is high for one cycle when the counter equals all-ones.
REQ-010 FSM states: IDLE, ON and GAP; only this FSM drives outsig.
REQ-011 outsig is 1 in ON and 0 in IDLE and GAP.
REQ-012 IDLE: trig=1 at a posedge moves the FSM to ON at that edge, so outsig is high from the next cycle; tick-count clears to 0.
REQ-013 ON: each tick increments the tick-count; the tick that reaches ON_TICKS exits ON.
REQ-014 The ON exit goes to GAP if OFF_TICKS>0; otherwise it goes to ON if a trigger is pending, else to IDLE.
REQ-015 A tick coincident with entry into ON is not counted, so outsig high time is between (ON_TICKS-1)*2^DIV_W+1 and ON_TICKS*2^DIV_W cycles inclusive.
REQ-016 GAP: each tick increments the tick-count; the tick that reaches OFF_TICKS exits GAP.
REQ-017 The GAP exit goes to ON (count cleared, pending cleared) if a trigger is pending, else to IDLE.
REQ-018 trig=1 in GAP sets the pending flag; the flag is 1 bit deep, so further triggers while it is set are dropped.
REQ-019 trig=1 in ON without PULSE_RETRIG_EN is ignored and does not set pending.
REQ-020 trig=1 on the same edge as an exit from ON or GAP: the trigger is honoured and the transition follows REQ-014 or REQ-017 with pending treated as set.
REQ-021 The tick-count is 8 bits wide and cannot overflow within the legal parameter range.

Reset
REQ-022 reset=1 asynchronously forces: prescaler=0, state=IDLE, tick-count=0, pending=0, outsig=0, busy=0.
REQ-023 Reset asserted mid-pulse truncates the pulse immediately; no trigger survives reset.
REQ-024 The first trig after reset release is handled per REQ-012.

Configuration
REQ-025 Macro PULSE_RETRIG_EN defined: trig=1 in ON clears the tick-count, restarting the full ON period; pending is unaffected.
REQ-026 Macro PULSE_RETRIG_EN undefined: REQ-019 applies, and no retrigger logic is synthesised.

Structure
REQ-027 Shared package pulse_stretch_pkg holds the state enum typedef (IDLE, ON, GAP) and the default constants for DIV_W, ON_TICKS and OFF_TICKS.
REQ-028 The prescaler (REQ-009) is the sub-module tick_prescaler, with ports clk, reset, tick and parameter DIV_W; it is reusable by the existing debounce block.

Verification
REQ-029 Bench parameters: DIV_W=2, ON_TICKS=3, OFF_TICKS=2; tick every 4 cycles.
REQ-030 Single trig pulse in IDLE -> outsig rises the next cycle, stays high 9..12 cycles, then busy stays high through GAP for 5..8 cycles before returning to 0.
REQ-031 Trig during GAP -> outsig goes high again immediately at GAP exit, with exactly OFF_TICKS ticks of low time; a second and third trig in the same GAP produce only one pulse.
REQ-032 Without the macro, trig repeated every cycle during ON -> pulse length is unchanged at 9..12 cycles; with PULSE_RETRIG_EN, the last trig in ON plus 9..12 cycles gives the fall time.
REQ-033 reset asserted for 1 cycle at mid-ON -> outsig=0 and busy=0 in the same cycle, prescaler restarts from 0, and a later trig gives a full-length pulse.
REQ-034 OFF_TICKS=0 with trig held high -> outsig stays continuously high across the ON-to-ON transition and busy never drops.

Source files
------------

// File: rtl/pulse_stretch_pkg.sv
// Shared types and default constants for the pulse stretcher and its prescaler.
package pulse_stretch_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam int DEF_DIV_W     = 15;
  localparam int DEF_ON_TICKS  = 10;
  localparam int DEF_OFF_TICKS = 2;
  localparam int TCNT_W        = 8;
endpackage

// File: rtl/pulse_stretch_if.sv
// Request/indicator bundle of the pulse stretcher plus FSM state for observation.
interface pulse_stretch_if;
  // trig: one-cycle (or held) request sampled every clk; no ready, requests
  // arriving while a pulse is active are absorbed or dropped by the stretcher.
  // outsig/busy/state are registered outputs of the stretcher.
  logic                      trig;
  logic                      outsig;
  logic                      busy;
  pulse_stretch_pkg::state_e state;

  modport master (output trig, input outsig, input busy, input state);
  modport slave  (input trig, output outsig, output busy, output state);
endinterface

// File: rtl/tick_prescaler.sv
// Free-running DIV_W-bit counter; tick is high for the cycle the count is all-ones.
module tick_prescaler #(
  parameter int DIV_W = pulse_stretch_pkg::DEF_DIV_W
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  localparam logic [DIV_W-1:0] ONE = 1;

  logic [DIV_W-1:0] cnt_q, cnt_d;

  always_comb cnt_d = cnt_q + ONE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick = &cnt_q;
endmodule

// File: rtl/pulse_stretch.sv
// Stretches trigger events into ON_TICKS-long pulses separated by OFF_TICKS of low.
// Optional feature: define PULSE_RETRIG_EN to let a trigger during ON restart the ON period.
module pulse_stretch
  import pulse_stretch_pkg::*;
#(
  parameter int DIV_W     = DEF_DIV_W,
  parameter int ON_TICKS  = DEF_ON_TICKS,
  parameter int OFF_TICKS = DEF_OFF_TICKS
) (
  input logic            clk,
  input logic            reset,
  pulse_stretch_if.slave ps
);
  localparam logic [TCNT_W-1:0] ON_T  = TCNT_W'(ON_TICKS);
  localparam logic [TCNT_W-1:0] OFF_T = TCNT_W'(OFF_TICKS);

  logic              tick;
  state_e            state_q, state_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d, tcnt_inc;
  logic              pend_q, pend_d;
  logic              outsig_q, outsig_d;
  logic              busy_q, busy_d;

  tick_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      tcnt_q   <= '0;
      pend_q   <= 1'b0;
      outsig_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tcnt_q   <= tcnt_d;
      pend_q   <= pend_d;
      outsig_q <= outsig_d;
      busy_q   <= busy_d;
    end
  end

  assign tcnt_inc = tcnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    pend_d  = pend_q;
    case (state_q)
      IDLE: begin
        if (ps.trig) begin
          state_d = ON;
          tcnt_d  = '0;
          pend_d  = 1'b0;
        end
      end
      ON: begin
`ifdef PULSE_RETRIG_EN
        if (ps.trig) tcnt_d = '0;
        else
`endif
        if (tick) begin
          tcnt_d = tcnt_inc;
          if (tcnt_inc == ON_T) begin
            tcnt_d = '0;
            // A trigger landing on the exit edge counts as pending.
            if (OFF_TICKS > 0) begin
              state_d = GAP;
              pend_d  = pend_q | ps.trig;
            end else if (pend_q | ps.trig) begin
              state_d = ON;
              pend_d  = 1'b0;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      GAP: begin
        pend_d = pend_q | ps.trig;
        if (tick) begin
          tcnt_d = tcnt_inc;
          if (tcnt_inc == OFF_T) begin
            tcnt_d = '0;
            if (pend_q | ps.trig) begin
              state_d = ON;
              pend_d  = 1'b0;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    outsig_d = (state_d == ON);
    busy_d   = (state_d != IDLE) || pend_d;
  end

  assign ps.outsig = outsig_q;
  assign ps.busy   = busy_q;
  assign ps.state  = state_q;
endmodule

// File: tb/tb_pulse_stretch.sv
// Random and directed stimulus on two stretchers (OFF_TICKS=2 and OFF_TICKS=0) checked against a tick-countdown model.
module tb_pulse_stretch;
  import pulse_stretch_pkg::*;

  localparam int DW   = 2;
  localparam int ONT  = 3;
  localparam int OFFT = 2;
  localparam int PER  = 1 << DW;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic trig  = 1'b0;
  int   cyc_cnt = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  pulse_stretch_if if_a ();
  pulse_stretch_if if_b ();
  assign if_a.trig = trig;
  assign if_b.trig = trig;

  pulse_stretch #(.DIV_W(DW), .ON_TICKS(ONT), .OFF_TICKS(OFFT)) dut_a (
    .clk(clk), .reset(reset), .ps(if_a.slave));
  pulse_stretch #(.DIV_W(DW), .ON_TICKS(ONT), .OFF_TICKS(0)) dut_b (
    .clk(clk), .reset(reset), .ps(if_b.slave));

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // behavioural model: phase 0 idle, 1 on, 2 gap; left = ticks remaining in phase
  typedef struct {
    int phase;
    int left;
    bit pend;
    int pre;
  } m_t;

  m_t ma, mb;
  logic [1:0] exp_a_q[$];
  logic [1:0] exp_b_q[$];

  function automatic m_t m_init();
    m_t m;
    m.phase = 0; m.left = 0; m.pend = 1'b0; m.pre = 0;
    return m;
  endfunction

  function automatic m_t m_step(m_t m_in, bit t, int off);
    m_t m;
    bit tk;
    m = m_in;
    tk = (m.pre == PER - 1);
    m.pre = (m.pre + 1) % PER;
    case (m.phase)
      0: if (t) begin m.phase = 1; m.left = ONT; end
      1: begin
`ifdef PULSE_RETRIG_EN
        if (t) m.left = ONT;
        else
`endif
        if (tk) begin
          m.left = m.left - 1;
          if (m.left == 0) begin
            if (off > 0) begin m.phase = 2; m.left = off; m.pend = t; end
            else if (t) m.left = ONT;
            else m.phase = 0;
          end
        end
      end
      default: begin
        m.pend = m.pend | t;
        if (tk) begin
          m.left = m.left - 1;
          if (m.left == 0) begin
            if (m.pend) begin m.phase = 1; m.left = ONT; m.pend = 1'b0; end
            else m.phase = 0;
          end
        end
      end
    endcase
    return m;
  endfunction

  function automatic logic [1:0] m_exp(m_t m);
    return {(m.phase != 0) || m.pend, m.phase == 1};
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ma <= m_init();
      mb <= m_init();
      exp_a_q.delete();
      exp_b_q.delete();
      exp_a_q.push_back(2'b00);
      exp_b_q.push_back(2'b00);
    end else begin
      exp_a_q.push_back(m_exp(m_step(ma, trig, OFFT)));
      exp_b_q.push_back(m_exp(m_step(mb, trig, 0)));
      ma <= m_step(ma, trig, OFFT);
      mb <= m_step(mb, trig, 0);
    end
  end

  // scoreboard helpers
  task automatic check2(input string nm, input logic [1:0] act, input logic [1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got busy/outsig=%b want %b at cycle %0d", nm, act, exp, cyc_cnt);
    end
  endtask

  task automatic check_range(input string nm, input int v, input int lo, input int hi);
    n_cmp++;
    if (v < lo || v > hi) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d..%0d", nm, v, lo, hi);
    end
  endtask

  always @(negedge clk) begin
    if (exp_a_q.size() > 0) check2("cyc_a", {if_a.busy, if_a.outsig}, exp_a_q.pop_front());
    if (exp_b_q.size() > 0) check2("cyc_b", {if_b.busy, if_b.outsig}, exp_b_q.pop_front());
  end

  // driver tasks (inputs change 1 time unit after the falling edge)
  task automatic cyc(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic pulse_trig();
    trig = 1'b1; cyc(1); trig = 1'b0;
  endtask

  task automatic wait_out_a(input logic val, output int t);
    int g;
    g = 0;
    while (if_a.outsig !== val && g < 200) begin @(negedge clk); g++; end
    if (g >= 200) begin
      n_cmp++; n_err++;
      $display("FAIL wait_outsig: timeout, got %b want %b", if_a.outsig, val);
    end
    t = cyc_cnt;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check2("rst_now_a", {if_a.busy, if_a.outsig}, 2'b00);
    check2("rst_now_b", {if_b.busy, if_b.outsig}, 2'b00);
    cyc(1);
    reset = 1'b0;
  endtask

  // right after reset release: prescaler phase is known, so the length is exact
  task automatic fresh_pulse_len(input string nm);
    int t_r, t_f;
    cyc(1);
    trig = 1'b1; cyc(1); trig = 1'b0;
    t_r = cyc_cnt;
    wait_out_a(1'b0, t_f);
    check_range(nm, t_f - t_r, 10, 10);
  endtask

  initial begin
    int t_r, t_f, t_f2, t_last, n, rises;
    logic prev;

    cyc(2);
    check2("init_a", {if_a.busy, if_a.outsig}, 2'b00);
    check2("init_b", {if_b.busy, if_b.outsig}, 2'b00);
    cyc(1);
    reset = 1'b0;

    // single pulse: length, then GAP busy time
    fresh_pulse_len("t1_len");
    n = 0;
    while (if_a.busy && n < 200) begin n++; @(negedge clk); end
    check_range("t1_gap_busy", n, 8, 8);
    check_range("t1_gap_range", n, 5, 8);
    #1;

    // triggers during GAP: exactly one follow-up pulse after OFF_TICKS ticks
    cyc(3);
    pulse_trig();
    wait_out_a(1'b0, t_f);
    #1;
    pulse_trig(); cyc(1);
    pulse_trig(); cyc(1);
    pulse_trig();
    wait_out_a(1'b1, t_r);
    check_range("t2_low_time", t_r - t_f, OFFT * PER, OFFT * PER);
    wait_out_a(1'b0, t_f2);
    check_range("t2_len2", t_f2 - t_r, 9, 12);
    rises = 0;
    prev = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (if_a.outsig && !prev) rises++;
      prev = if_a.outsig;
    end
    check_range("t2_extra_pulses", rises, 0, 0);
    check2("t2_idle", {if_a.busy, if_a.outsig}, 2'b00);
    #1;

    // repeated trig during ON
    cyc(5);
    trig = 1'b1; cyc(1);
    t_r = cyc_cnt;
    cyc(6);
    t_last = cyc_cnt;
    trig = 1'b0;
    wait_out_a(1'b0, t_f);
`ifdef PULSE_RETRIG_EN
    check_range("t3_retrig_fall", t_f - t_last, 9, 12);
`else
    check_range("t3_len_unchanged", t_f - t_r, 9, 12);
`endif
    #1;

    // reset in the middle of ON, then a full-length pulse
    cyc(30);
    pulse_trig();
    cyc(4);
    do_reset();
    fresh_pulse_len("t4_len");
    #1;

    // OFF_TICKS=0 instance with trig held: continuously high, never idle
    cyc(20);
    trig = 1'b1; cyc(1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check2("t5_held_b", {if_b.busy, if_b.outsig}, 2'b11);
    end
    #1;
    trig = 1'b0;
    cyc(30);

    // random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 249) == 0) do_reset();
      else begin
        trig = ($urandom_range(0, 7) == 0);
        cyc(1);
      end
    end
    trig = 1'b0;
    cyc(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
